sp_dram_word_port: RTL

Word-width front end for the LPDDR line controller `sp_dram`. It accepts single-word read and write requests from a kernel memory port and turns them into 128-bit line accesses with byte masks. It keeps a one-line read buffer so repeated reads within a line are served without a DRAM access. It sits between the generated kernel logic (upstream) and `sp_dram` (downstream), in the `clk` domain produced by `sp_dram`.

---
 rtl/sp_dram_pkg.sv | 41 ++++
 rtl/sp_dram_line_buf.sv | 44 ++++
 rtl/sp_dram_word_port.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sp_dram_pkg.sv
// Shared constants, FSM encoding and byte-lane helpers for the sp_dram word port.
package sp_dram_pkg;

    localparam int LINE_BITS      = 128;
    localparam int LINE_ADDR_BITS = 25;
    localparam int MASK_BITS      = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_REQ   = 3'd1,
        ST_RD_WAIT0 = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_WR_REQ   = 3'd4
    } state_t;

    // Byte enables covering word `sel` of a line built from `bytes`-wide words.
    function automatic logic [MASK_BITS-1:0] word_mask(input int sel, input int bytes);
        logic [MASK_BITS-1:0] m;
        m = '0;
        for (int b = 0; b < MASK_BITS; b++) begin
            m[b] = (b >= sel * bytes) && (b < (sel + 1) * bytes);
        end
        return m;
    endfunction

    function automatic logic [LINE_BITS-1:0] merge_bytes(
        input logic [LINE_BITS-1:0] old_line,
        input logic [LINE_BITS-1:0] new_line,
        input logic [MASK_BITS-1:0] mask
    );
        logic [LINE_BITS-1:0] r;
        r = old_line;
        for (int b = 0; b < MASK_BITS; b++) begin
            if (mask[b]) begin
                r[b*8 +: 8] = new_line[b*8 +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sp_dram_line_buf.sv
// One-line read buffer: data, tag and valid, with hit compare and write-through byte merge.
module sp_dram_line_buf
    import sp_dram_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LINE_ADDR_BITS-1:0] lookup_addr,
    output logic                      hit,
    output logic [LINE_BITS-1:0]      data,
    input  logic                      fill_en,
    input  logic [LINE_ADDR_BITS-1:0] fill_tag,
    input  logic [LINE_BITS-1:0]      fill_data,
    input  logic                      merge_en,
    input  logic [LINE_BITS-1:0]      merge_data,
    input  logic [MASK_BITS-1:0]      merge_mask
);

    logic [LINE_BITS-1:0]      data_q;
    logic [LINE_ADDR_BITS-1:0] tag_q;
    logic                      valid_q;

    assign hit  = valid_q && (tag_q == lookup_addr);
    assign data = data_q;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (fill_en) begin
            valid_q <= 1'b1;
        end
    end

    // NOTE: data and tag are deliberately left out of reset; valid_q gates every use of them.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_q <= fill_data;
            tag_q  <= fill_tag;
        end else if (merge_en && hit) begin
            data_q <= merge_bytes(data_q, merge_data, merge_mask);
        end
    end

endmodule

// File: rtl/sp_dram_word_port.sv
// Word-width request port in front of the sp_dram line controller, with a one-line
// read buffer and write-through (no allocate) on writes.
module sp_dram_word_port
    import sp_dram_pkg::*;
#(
    parameter  int WIDTH      = 32,
    localparam int WORDS      = LINE_BITS / WIDTH,
    localparam int SEL_BITS   = $clog2(WORDS),
    localparam int ADDR_WIDTH = LINE_ADDR_BITS + SEL_BITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     addr_in,
    input  logic [WIDTH-1:0]          din_in,
    input  logic                      we_in,
    input  logic                      re_in,
    output logic                      ready_out,
    output logic [WIDTH-1:0]          dout_out,
    output logic                      rvalid_out,
    output logic [LINE_ADDR_BITS-1:0] mem_addr,
    output logic [LINE_BITS-1:0]      mem_din,
    output logic [MASK_BITS-1:0]      mem_mask,
    output logic                      mem_we,
    output logic                      mem_re,
    input  logic [LINE_BITS-1:0]      mem_dout,
    input  logic                      mem_ready
);

    localparam int BYTES = WIDTH / 8;
    localparam int SEL_W = (SEL_BITS > 0) ? SEL_BITS : 1;

    state_t                    state;
    state_t                    state_next;
    logic [LINE_ADDR_BITS-1:0] line_in;
    logic [SEL_W-1:0]          sel_in;
    logic [SEL_W-1:0]          sel_q;
    logic [LINE_ADDR_BITS-1:0] lookup_addr;
    logic                      buf_hit;
    logic [LINE_BITS-1:0]      buf_data;
    logic                      accept_wr;
    logic                      accept_rd_hit;
    logic                      accept_rd_miss;
    logic                      fill;

    assign line_in = addr_in[ADDR_WIDTH-1 -: LINE_ADDR_BITS];

    // A full-line client has no word select; tie it to word 0.
    generate
        if (SEL_BITS > 0) begin : g_sel
            assign sel_in = addr_in[SEL_W-1:0];
        end else begin : g_nosel
            assign sel_in = '0;
        end
    endgenerate

    assign ready_out = (state == ST_IDLE);

    // New requests look up the incoming line; a pending write looks up its own line.
    assign lookup_addr = (state == ST_IDLE) ? line_in : mem_addr;

    sp_dram_line_buf u_line_buf (
        .clk         (clk),
        .rst         (rst),
        .lookup_addr (lookup_addr),
        .hit         (buf_hit),
        .data        (buf_data),
        .fill_en     (fill),
        .fill_tag    (mem_addr),
        .fill_data   (mem_dout),
        .merge_en    (mem_we),
        .merge_data  (mem_din),
        .merge_mask  (mem_mask)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next     = state;
        mem_re         = 1'b0;
        mem_we         = 1'b0;
        accept_wr      = 1'b0;
        accept_rd_hit  = 1'b0;
        accept_rd_miss = 1'b0;
        fill           = 1'b0;
        case (state)
            ST_IDLE: begin
                if (we_in) begin
                    accept_wr  = 1'b1;
                    state_next = ST_WR_REQ;
                end else if (re_in) begin
                    if (buf_hit) begin
                        accept_rd_hit = 1'b1;
                    end else begin
                        accept_rd_miss = 1'b1;
                        state_next     = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                mem_re = mem_ready;
                if (mem_ready) begin
                    state_next = ST_RD_WAIT0;
                end
            end
            // sp_dram lowers ready one cycle after the read strobe; skip that cycle.
            ST_RD_WAIT0: begin
                state_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (mem_ready) begin
                    fill       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                mem_we = mem_ready;
                if (mem_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr   <= '0;
            mem_din    <= '0;
            mem_mask   <= '0;
            sel_q      <= '0;
            dout_out   <= '0;
            rvalid_out <= 1'b0;
        end else begin
            rvalid_out <= accept_rd_hit || fill;

            if (accept_wr) begin
                mem_addr <= line_in;
                mem_din  <= {WORDS{din_in}};
                mem_mask <= word_mask(int'(sel_in), BYTES);
            end else if (accept_rd_miss) begin
                mem_addr <= line_in;
                sel_q    <= sel_in;
            end

            if (accept_rd_hit) begin
                dout_out <= buf_data[int'(sel_in)*WIDTH +: WIDTH];
            end else if (fill) begin
                dout_out <= mem_dout[int'(sel_q)*WIDTH +: WIDTH];
            end
        end
    end

endmodule
